// File: rtl/nxs_uart_pkg.sv
// Shared definitions for the FKNXS UART transmit and receive paths.
package nxs_uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned NONCE_BYTES = 8;

  // 600 MHz / 115200 baud, shared with the work receiver.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;

endpackage

// File: rtl/nonce_uart_tx_if.sv
// Nonce handoff from the hash core: single-cycle strobe plus 64-bit payload.
interface nonce_uart_tx_if;

  logic        NonceValid;
  logic [63:0] NonceIn;

  modport master (output NonceValid, output NonceIn);
  modport slave  (input NonceValid, input NonceIn);

endinterface

// File: rtl/nonce_fifo.sv
// Small synchronous FIFO with count-based full/empty; head is read combinationally.
module nonce_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CountW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  // A push while full is ignored; a simultaneous pop does not make room for it.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CountW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CountW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nonce_uart_tx.sv
// Buffered nonce return path: queues nonces and sends each as 8 bytes of 8N1, LSB byte first.
module nonce_uart_tx
  import nxs_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   nRst,
  nonce_uart_tx_if.slave         nonce_if,
  output logic                   UART_RXD_OUT,
  output logic                   Busy,
  output logic                   FifoFull,
  output logic [7:0]             DropCount
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);

  tx_state_e         state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [63:0]       shift_q, shift_d;
  logic              line_q, line_d;
  logic [7:0]        drop_q, drop_d;

  logic        fifo_full, fifo_empty, fifo_pop, tick;
  logic [63:0] fifo_head;

  assign fifo_pop = (state_q == StIdle) && !fifo_empty;
  assign tick     = (timer_q == TimerW'(CLKS_PER_BIT - 1));

  nonce_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (64)
  ) u_fifo (
    .clk     (clk),
    .nRst    (nRst),
    .push_i  (nonce_if.NonceValid && !fifo_full),
    .pop_i   (fifo_pop),
    .wdata_i (nonce_if.NonceIn),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Serializer FSM, bit timer and line level; the line follows the current state one cycle later.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    line_d  = 1'b1;
    unique case (state_q)
      StIdle: begin
        line_d = 1'b1;
        if (!fifo_empty) begin
          shift_d = fifo_head;
          byte_d  = '0;
          timer_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        line_d = 1'b0;
        if (tick) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StData: begin
        line_d = shift_q[0];
        if (tick) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StStop: begin
        line_d = 1'b1;
        if (tick) begin
          timer_d = '0;
          if (byte_q == 3'(NONCE_BYTES - 1)) begin
            state_d = StIdle;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = StStart;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
    endcase
  end

  // Saturating count of nonces rejected because the queue was full.
  always_comb begin
    drop_d = drop_q;
    if (nonce_if.NonceValid && fifo_full && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State registers; reset forces the line high immediately.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= StIdle;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      drop_q  <= drop_d;
    end
  end

  assign UART_RXD_OUT = line_q;
  assign Busy         = !fifo_empty || (state_q != StIdle);
  assign FifoFull     = fifo_full;
  assign DropCount    = drop_q;

endmodule
